// File: rtl/ctrl_pipe.sv
// ctrl_pipe -- pipeline control for a 5-stage MIPS-style core.
// Shifts the decoder control bundle ID->EX->MEM->WB, detects load-use
// hazards, handles taken-branch and jump flushes, and (optionally) interlocks
// a 32-cycle multi-cycle MULTU against dependent MULTU/MFHI/MFLO.
// Optional feature macro: MULTU_INTERLOCK_EN (undefined = no multiplier
// interlock, multu_busy tied low).
// Bundle layout: [9]RegDst [8]ALUSrc [7]MemtoReg [6]RegWrite [5]MemRead
//                [4]MemWrite [3]Branch [2]Jump [1:0]ALUOp
module ctrl_pipe (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    input  logic [9:0] id_ctrl,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_multu,
    input  logic       id_mfhilo,
    input  logic       ex_taken,
    output logic       pc_write,
    output logic       ifid_write,
    output logic       ifid_flush,
    output logic [9:0] ex_ctrl,
    output logic [4:0] ex_rt,
    output logic [3:0] mem_ctrl,
    output logic [1:0] wb_ctrl,
    output logic       multu_busy
);

    localparam int unsigned BIT_MEMREAD = 5;
    localparam int unsigned BIT_JUMP    = 2;

    // Stage registers
    logic [9:0] r_ex_ctrl;
    logic [4:0] r_ex_rt;
    logic [3:0] r_mem_ctrl;
    logic [1:0] r_wb_ctrl;

    // Hazard / steering wires
    logic [9:0] w_id_ctrl;
    logic       w_load_use;
    logic       w_mul_stall;
    logic       w_bubble;
    logic       w_pc_write;
    logic       w_ifid_write;
    logic       w_ifid_flush;

`ifdef MULTU_INTERLOCK_EN
    logic [5:0] r_mul_cnt;
    logic       w_mul_start;

    // Multiplier interlock: dependent multiply-unit ops wait while busy
    always_comb begin
        w_mul_stall = 1'b0;
        if (id_valid && (id_multu || id_mfhilo) && (r_mul_cnt != 6'd0)) begin
            w_mul_stall = 1'b1;
        end else begin
            w_mul_stall = 1'b0;
        end
    end

    // A MULTU starts only when it actually enters EX (not bubbled/squashed)
    assign w_mul_start = rst && id_valid && id_multu && !w_bubble;
    assign multu_busy  = (r_mul_cnt != 6'd0);

    // Multiply occupancy down-counter: 32 cycles from acceptance into EX
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mul_cnt <= 6'd0;
        end else if (w_mul_start) begin
            r_mul_cnt <= 6'd32;
        end else if (r_mul_cnt != 6'd0) begin
            r_mul_cnt <= r_mul_cnt - 6'd1;
        end else begin
            r_mul_cnt <= r_mul_cnt;
        end
    end
`else
    logic w_unused_mul;

    // Multiply-unit decode has no effect when the interlock is compiled out
    assign w_unused_mul = id_multu ^ id_mfhilo;
    assign w_mul_stall  = 1'b0;
    assign multu_busy   = 1'b0;
`endif

    // An invalid ID slot contributes an all-zero bundle (blocks decoder X)
    always_comb begin
        w_id_ctrl = 10'd0;
        if (id_valid) begin
            w_id_ctrl = id_ctrl;
        end else begin
            w_id_ctrl = 10'd0;
        end
    end

    // Load-use: the load in EX writes a register the ID instruction reads
    always_comb begin
        w_load_use = 1'b0;
        if (id_valid && r_ex_ctrl[BIT_MEMREAD] && (r_ex_rt != 5'd0) &&
            ((r_ex_rt == id_rs) || (r_ex_rt == id_rt))) begin
            w_load_use = 1'b1;
        end else begin
            w_load_use = 1'b0;
        end
    end

    // Priority steering: taken branch > load-use > multiply interlock > jump
    always_comb begin
        w_pc_write   = 1'b1;
        w_ifid_write = 1'b1;
        w_ifid_flush = 1'b0;
        w_bubble     = 1'b0;
        if (!rst) begin
            // Reset releases any stall immediately
            w_pc_write   = 1'b1;
            w_ifid_write = 1'b1;
            w_ifid_flush = 1'b0;
            w_bubble     = 1'b1;
        end else if (ex_taken) begin
            w_pc_write   = 1'b1;
            w_ifid_write = 1'b1;
            w_ifid_flush = 1'b1;
            w_bubble     = 1'b1;
        end else if (w_load_use || w_mul_stall) begin
            w_pc_write   = 1'b0;
            w_ifid_write = 1'b0;
            w_ifid_flush = 1'b0;
            w_bubble     = 1'b1;
        end else if (w_id_ctrl[BIT_JUMP]) begin
            // The jump itself proceeds; only the wrong-path fetch is killed
            w_pc_write   = 1'b1;
            w_ifid_write = 1'b1;
            w_ifid_flush = 1'b1;
            w_bubble     = 1'b0;
        end else begin
            w_pc_write   = 1'b1;
            w_ifid_write = 1'b1;
            w_ifid_flush = 1'b0;
            w_bubble     = 1'b0;
        end
    end

    // Control bundle shift register: EX gets ID or a bubble, MEM/WB subsets
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ex_ctrl  <= 10'd0;
            r_ex_rt    <= 5'd0;
            r_mem_ctrl <= 4'd0;
            r_wb_ctrl  <= 2'd0;
        end else begin
            if (w_bubble) begin
                r_ex_ctrl <= 10'd0;
                r_ex_rt   <= 5'd0;
            end else if (!id_valid) begin
                r_ex_ctrl <= 10'd0;
                r_ex_rt   <= 5'd0;
            end else begin
                r_ex_ctrl <= w_id_ctrl;
                r_ex_rt   <= id_rt;
            end
            r_mem_ctrl <= r_ex_ctrl[7:4];
            r_wb_ctrl  <= r_mem_ctrl[3:2];
        end
    end

    assign pc_write   = w_pc_write;
    assign ifid_write = w_ifid_write;
    assign ifid_flush = w_ifid_flush;
    assign ex_ctrl    = r_ex_ctrl;
    assign ex_rt      = r_ex_rt;
    assign mem_ctrl   = r_mem_ctrl;
    assign wb_ctrl    = r_wb_ctrl;

endmodule

// File: doc/ctrl_pipe.md
CTRL_PIPE -- requirements
Module: ctrl_pipe

Interface
REQ-001 SHALL: clk  in  1  single clock; all state changes on rising edge.
REQ-002 SHALL: rst  in  1  reset, synchronous, active-low.
REQ-003 SHALL: id_valid  in  1  ID stage holds a real instruction; when 0, ID control inputs are ignored and treated as all-zero.
REQ-004 SHALL: id_ctrl  in  10  decoder bundle {RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump, ALUOp[1:0]}.
REQ-005 SHALL: id_rs, id_rt  in  5 each  ID source register numbers.
REQ-006 SHALL: id_multu, id_mfhilo  in  1 each  ID holds MULTU or MFHI/MFLO (funct-decoded by datapath).
REQ-007 SHALL: ex_taken  in  1  branch in EX resolved taken.
REQ-008 SHALL: pc_write, ifid_write  out  1 each  PC and IF/ID register enables.
REQ-009 SHALL: ifid_flush  out  1  zero the IF/ID register next edge.
REQ-010 SHALL: ex_ctrl  out  10  ID/EX control; ex_rt  out  5  ID/EX rt copy.
REQ-011 SHALL: mem_ctrl  out  4  {MemtoReg, RegWrite, MemRead, MemWrite}; wb_ctrl  out  2  {MemtoReg, RegWrite}.
REQ-012 SHALL: multu_busy  out  1  multiplier occupied.

Function
REQ-013 SHALL: shift control bundle ID->EX->MEM->WB one stage per cycle; mem_ctrl/wb_ctrl are field subsets of the previous stage.
REQ-014 SHALL: bubble = all-zero bundle; X from decoder never reaches ex_ctrl when a bubble is inserted.
REQ-015 SHALL: load-use hazard = ex_ctrl.MemRead & ex_rt!=0 & (ex_rt==id_rs | ex_rt==id_rt) & id_valid.
REQ-016 SHALL: on load-use, pc_write=0, ifid_write=0, bubble into EX; exactly one stall cycle per hazard.
REQ-017 SHALL: on ex_taken, ifid_flush=1, bubble into EX, pc_write=1; overrides every stall in the same cycle.
REQ-018 SHALL: on id_ctrl.Jump & id_valid (no ex_taken), ifid_flush=1, Jump bundle proceeds to EX.
REQ-019 SHALL: priority ex_taken > load-use > MULTU interlock > jump flush.
REQ-020 SHALL: MULTU accepted into EX loads a 6-bit down-counter with 32; multu_busy=1 while counter!=0; decrement once per cycle.
REQ-021 SHALL: MULTU in ID while multu_busy stalls as REQ-016 until counter reaches 0.
REQ-022 SHALL: combinational outputs (pc_write, ifid_write, ifid_flush) have zero latency from inputs; registered outputs update on the next edge.
REQ-023 SHALL: MULTU squashed by ex_taken never starts the counter.

Reset
REQ-024 SHALL: with rst=0 at an edge: ex_ctrl, mem_ctrl, wb_ctrl, ex_rt=0; counter=0; multu_busy=0.
REQ-025 SHALL: while rst=0, pc_write=1, ifid_write=1, ifid_flush=0; reset mid-stall or mid-multiply aborts it with no residual stall.

Configuration
REQ-026 SHALL: macro MULTU_INTERLOCK_EN defined: REQ-020/021 and the MFHI/MFLO stall of REQ-027 apply.
REQ-027 SHALL: with MULTU_INTERLOCK_EN, id_mfhilo & id_valid while multu_busy stalls as REQ-016.
REQ-028 SHALL: without MULTU_INTERLOCK_EN: no counter, multu_busy tied 0, MULTU/MFHI/MFLO never stall.

Verification
REQ-029 SHALL: lw $2 then add $3,$2,$4 -> one cycle pc_write=0, ifid_write=0, ex_ctrl=0; add reaches EX next cycle with RegDst=1, ALUOp=10.
REQ-030 SHALL: beq in EX with ex_taken=1 while load-use active -> ifid_flush=1, pc_write=1, ex_ctrl=0 that cycle.
REQ-031 SHALL: j in ID -> ifid_flush=1 one cycle, ex_ctrl.Jump=1 next cycle, mem_ctrl carries no Jump.
REQ-032 SHALL: sw bundle -> mem_ctrl MemWrite=1 at cycle+2, wb_ctrl RegWrite=0 at cycle+3.
REQ-033 SHALL: MULTU then MFLO (MULTU_INTERLOCK_EN) -> multu_busy=1 for 32 cycles, MFLO stalled until busy=0; without macro, no stall.
REQ-034 SHALL: rst=0 asserted at cycle 10 of multiply -> next cycle multu_busy=0, all stage bundles 0, pc_write=1.
